// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM state type and timer width for the load/store unit
package lsu_pkg;
  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;
  localparam int TIMER_W = 8;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;
  function automatic logic illegal_funct(input logic [2:0] f, input logic we);
    return f == 3'b011 || f == 3'b110 || f == 3'b111 || (f[2] && we);
  endfunction
endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: synchronous data-memory port (req/gnt address phase, rvalid read-data phase)
//   master = load/store controller, slave = memory
//   req/we/be/addr/wdata: request, held until gnt; gnt: request accepted this cycle
//   rvalid/rdata: read word, at least one cycle after gnt, loads only
interface lsu_mem_ctrl_if;
  logic req, we, gnt, rvalid;
  logic [3:0] be;
  logic [31:0] addr, wdata, rdata;
  modport master(output req, we, be, addr, wdata, input gnt, rvalid, rdata);
  modport slave(input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the byte/halfword lane of a raw read word and sign/zero extends it
//   funct: RV32I load funct3; off: byte offset addr[1:0]; raw: memory word; data: extended result
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct,
  input  logic [1:0]  off,
  input  logic [31:0] raw,
  output logic [31:0] data
);
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    b = raw[{off, 3'b000} +: 8];
    h = off[1] ? raw[31:16] : raw[15:0];
    data = funct[1:0] == F_B[1:0] ? {{24{b[7] & ~funct[2]}}, b} :
           funct[1:0] == F_H[1:0] ? {{16{h[15] & ~funct[2]}}, h} : raw;
  end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: single-outstanding load/store sequencer between execute and the data memory port
//   clk, rst_n (sync, active-low)
//   req_valid/req_ready/req_we/req_funct/req_addr/req_wdata: request handshake from execute
//   rsp_valid/rsp_rdata/rsp_err: one-cycle response per accepted request
//   mem: lsu_mem_ctrl_if.master memory port
//   LSU_MISALIGN_TRAP_EN: misaligned H/W accesses respond with an error instead of
//   having their offending low address bits cleared
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  lsu_mem_ctrl_if.master        mem
);
  state_t state, state_nx;
  logic we_q, err_q, misalign, bad, timeout, in_req;
  logic [2:0] funct_q;
  logic [31:0] addr_q, wdata_q, rdata_q, addr_in, load_data;
  logic [TIMER_W-1:0] timer;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (req_funct[1:0] == F_H[1:0] && req_addr[0]) ||
                    (req_funct[1:0] == F_W[1:0] && req_addr[1:0] != 2'b00);
  assign addr_in = req_addr;
`else
  assign misalign = 1'b0;
  assign addr_in = req_funct[1:0] == F_H[1:0] ? {req_addr[31:1], 1'b0} :
                   req_funct[1:0] == F_W[1:0] ? {req_addr[31:2], 2'b00} : req_addr;
`endif
  assign bad = illegal_funct(req_funct, req_we) || misalign;
  // timer counts from 0 in the first cycle of REQ/WAIT_R, so TIMEOUT cycles elapse at TIMEOUT-1
  assign timeout = timer == TIMER_W'(TIMEOUT - 1);
  assign in_req = state == REQ;
  lsu_load_align u_align (.funct(funct_q), .off(addr_q[1:0]), .raw(mem.rdata), .data(load_data));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
      we_q <= 1'b0;
      funct_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= state_nx == state && (state == REQ || state == WAIT_R) ? timer + 1'b1 : '0;
      if (state == IDLE && req_valid) begin
        we_q <= req_we;
        funct_q <= req_funct;
        addr_q <= addr_in;
        wdata_q <= req_wdata;
        rdata_q <= '0;
        err_q <= bad;
      end
      if (state == WAIT_R && mem.rvalid) rdata_q <= load_data;
      if (((state == REQ && !mem.gnt) || (state == WAIT_R && !mem.rvalid)) && timeout) err_q <= 1'b1;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req_valid ? (bad ? RESP : REQ) : IDLE;
      REQ:     state_nx = mem.gnt ? (we_q ? RESP : WAIT_R) : timeout ? RESP : REQ;
      WAIT_R:  state_nx = mem.rvalid || timeout ? RESP : WAIT_R;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    req_ready = state == IDLE;
    rsp_valid = state == RESP;
    rsp_rdata = rsp_valid ? rdata_q : '0;
    rsp_err = rsp_valid && err_q;
    mem.req = in_req;
    mem.we = in_req && we_q;
    mem.addr = in_req ? {addr_q[31:2], 2'b00} : '0;
    mem.be = !in_req ? 4'b0000 :
             funct_q[1:0] == F_B[1:0] ? 4'b0001 << addr_q[1:0] :
             funct_q[1:0] == F_H[1:0] ? 4'b0011 << {addr_q[1], 1'b0} : 4'b1111;
    mem.wdata = !in_req ? '0 :
                funct_q[1:0] == F_B[1:0] ? {4{wdata_q[7:0]}} :
                funct_q[1:0] == F_H[1:0] ? {2{wdata_q[15:0]}} : wdata_q;
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: vector table plus scoreboard bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_we = 1'b0;
  logic [2:0] req_funct = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  int n_cmp = 0, n_bad = 0;

  typedef struct {
    bit we; bit [2:0] f; bit [31:0] a, wd, rd; int gd, rvd;
    bit [3:0] be; bit [31:0] ma, mwd, er; bit ee; int nreq, lat;
  } vec_t;
  typedef struct { bit [31:0] d; bit e; } exp_t;
  vec_t v[$];
  exp_t sb[$];

  lsu_mem_ctrl_if bus();

  lsu_mem_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct(req_funct), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem(bus)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 want no response");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_rdata", rsp_rdata, e.d);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e.e});
      end
    end
  end

  task automatic apply(input vec_t t, input int idx);
    int nreq = 0, wc = 0, lat = 0;
    bit granted = 0, done = 0;
    exp_t e;
    @(negedge clk);
    check($sformatf("v%0d_ready", idx), {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = t.we; req_funct = t.f; req_addr = t.a; req_wdata = t.wd;
    @(posedge clk);
    e.d = t.er; e.e = t.ee;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      bus.gnt = 1'b0; bus.rvalid = 1'b0;
      if (rsp_valid) begin
        lat = c + 1;
        done = 1;
      end else if (bus.req) begin
        if (nreq == 0) begin
          check($sformatf("v%0d_be", idx), {28'b0, bus.be}, {28'b0, t.be});
          check($sformatf("v%0d_maddr", idx), bus.addr, t.ma);
          check($sformatf("v%0d_mwdata", idx), bus.wdata, t.mwd);
          check($sformatf("v%0d_mwe", idx), {31'b0, bus.we}, {31'b0, t.we});
        end
        if (nreq == t.gd) begin bus.gnt = 1'b1; granted = 1; end
        nreq++;
      end else if (granted && !t.we) begin
        if (wc == t.rvd) begin bus.rvalid = 1'b1; bus.rdata = t.rd; end
        wc++;
      end
      if (!done) @(negedge clk);
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL v%0d_no_rsp: got no rsp_valid within 40 cycles want latency %0d", idx, t.lat);
      sb.delete();
    end
    check($sformatf("v%0d_nreq", idx), nreq, t.nreq);
    check($sformatf("v%0d_lat", idx), lat, t.lat);
  endtask

  initial begin
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    //        we    f       addr        wdata         rdata         gd  rvd be       maddr       mwdata        exp rdata     err  nreq lat
    v.push_back('{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        0,  0, 4'b1111, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 1,  2});
    v.push_back('{1'b0, 3'b000, 32'h203, 32'h0,        32'h80FF0000, 0,  0, 4'b1000, 32'h200, 32'h0,        32'hFFFFFF80, 1'b0, 1,  3});
    v.push_back('{1'b0, 3'b100, 32'h203, 32'h0,        32'h80FF0000, 0,  0, 4'b1000, 32'h200, 32'h0,        32'h00000080, 1'b0, 1,  3});
    v.push_back('{1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0,        0,  0, 4'b1100, 32'h100, 32'hABCDABCD, 32'h0,        1'b0, 1,  2});
    v.push_back('{1'b0, 3'b101, 32'h102, 32'h0,        32'hABCD1234, 0,  0, 4'b1100, 32'h100, 32'h0,        32'h0000ABCD, 1'b0, 1,  3});
    v.push_back('{1'b0, 3'b001, 32'h100, 32'h0,        32'h12348001, 0,  0, 4'b0011, 32'h100, 32'h0,        32'hFFFF8001, 1'b0, 1,  3});
    v.push_back('{1'b0, 3'b010, 32'h300, 32'h0,        32'hCAFEF00D, 2,  1, 4'b1111, 32'h300, 32'h0,        32'hCAFEF00D, 1'b0, 3,  6});
    v.push_back('{1'b1, 3'b000, 32'h301, 32'h12345677, 32'h0,        0,  0, 4'b0010, 32'h300, 32'h77777777, 32'h0,        1'b0, 1,  2});
    v.push_back('{1'b0, 3'b000, 32'h001, 32'h0,        32'h00007F00, 0,  0, 4'b0010, 32'h000, 32'h0,        32'h0000007F, 1'b0, 1,  3});
    v.push_back('{1'b1, 3'b010, 32'h400, 32'h11111111, 32'h0,        99, 0, 4'b1111, 32'h400, 32'h11111111, 32'h0,        1'b1, 15, 16});
    v.push_back('{1'b1, 3'b010, 32'h400, 32'h11111111, 32'h0,        14, 0, 4'b1111, 32'h400, 32'h11111111, 32'h0,        1'b0, 15, 16});
    v.push_back('{1'b0, 3'b010, 32'h404, 32'h0,        32'h00000077, 0, 99, 4'b1111, 32'h404, 32'h0,        32'h0,        1'b1, 1,  17});
    v.push_back('{1'b0, 3'b010, 32'h404, 32'h0,        32'h13579BDF, 0, 14, 4'b1111, 32'h404, 32'h0,        32'h13579BDF, 1'b0, 1,  17});
    v.push_back('{1'b0, 3'b011, 32'h010, 32'h0,        32'h0,        0,  0, 4'b0000, 32'h0,   32'h0,        32'h0,        1'b1, 0,  1});
    v.push_back('{1'b1, 3'b100, 32'h010, 32'h000000FF, 32'h0,        0,  0, 4'b0000, 32'h0,   32'h0,        32'h0,        1'b1, 0,  1});
    v.push_back('{1'b0, 3'b110, 32'h010, 32'h0,        32'h0,        0,  0, 4'b0000, 32'h0,   32'h0,        32'h0,        1'b1, 0,  1});
`ifdef LSU_MISALIGN_TRAP_EN
    v.push_back('{1'b0, 3'b010, 32'h101, 32'h0,        32'h55AA55AA, 0,  0, 4'b0000, 32'h0,   32'h0,        32'h0,        1'b1, 0,  1});
    v.push_back('{1'b0, 3'b001, 32'h103, 32'h0,        32'h9ABC0000, 0,  0, 4'b0000, 32'h0,   32'h0,        32'h0,        1'b1, 0,  1});
    v.push_back('{1'b1, 3'b001, 32'h101, 32'h0000BEEF, 32'h0,        0,  0, 4'b0000, 32'h0,   32'h0,        32'h0,        1'b1, 0,  1});
`else
    v.push_back('{1'b0, 3'b010, 32'h101, 32'h0,        32'h55AA55AA, 0,  0, 4'b1111, 32'h100, 32'h0,        32'h55AA55AA, 1'b0, 1,  3});
    v.push_back('{1'b0, 3'b001, 32'h103, 32'h0,        32'h9ABC0000, 0,  0, 4'b1100, 32'h100, 32'h0,        32'hFFFF9ABC, 1'b0, 1,  3});
    v.push_back('{1'b1, 3'b001, 32'h101, 32'h0000BEEF, 32'h0,        0,  0, 4'b0011, 32'h100, 32'hBEEFBEEF, 32'h0,        1'b0, 1,  2});
`endif
    repeat (3) @(negedge clk);
    check("reset_ready", {31'b0, req_ready}, 32'd1);
    check("reset_rsp", {30'b0, rsp_valid, rsp_err}, 32'd0);
    check("reset_rdata", rsp_rdata, 32'd0);
    check("reset_mem_ctl", {26'b0, bus.req, bus.we, bus.be}, 32'd0);
    check("reset_mem_addr", bus.addr | bus.wdata, 32'd0);
    rst_n = 1'b1;
    foreach (v[i]) apply(v[i], i);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct = 3'b010; req_addr = 32'h500;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_seq_req", {31'b0, bus.req}, 32'd1);
    bus.gnt = 1'b1;
    @(negedge clk);
    bus.gnt = 1'b0;
    check("rst_seq_wait_r", {31'b0, bus.req}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_seq_ready", {31'b0, req_ready}, 32'd1);
    check("rst_seq_no_rsp", {31'b0, rsp_valid}, 32'd0);
    bus.rvalid = 1'b1; bus.rdata = 32'hFEEDFACE;
    @(negedge clk);
    bus.rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_seq_late_rvalid", {31'b0, rsp_valid}, 32'd0);
      check("rst_seq_idle_ready", {31'b0, req_ready}, 32'd1);
      @(negedge clk);
    end
    apply(v[0], 99);
    repeat (2) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
